// File: rtl/jt49_noise_sweep.sv
// rtl/jt49_noise_sweep.sv - noise period sweep controller for the jt49 PSG noise generator
// Optional macro JT49_SWEEP_PINGPONG_EN: looping sweeps reverse direction instead of reloading the start value.
module jt49_noise_sweep #(
   parameter int RATE_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cen,
   input  logic              start,
   input  logic              stop,
   input  logic [4:0]        cfg_start,
   input  logic [4:0]        cfg_end,
   input  logic [4:0]        cfg_step,
   input  logic [RATE_W-1:0] cfg_rate,
   input  logic              cfg_loop,
   output logic [4:0]        period,
   output logic              wr,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      LAST = 2'd2
   } state_t;

   state_t            state, state_n;
   logic [4:0]        period_n;
   logic              wr_n, done_n;
   logic [RATE_W-1:0] cnt, cnt_n;
   logic [4:0]        s_lat, s_lat_n, e_lat, e_lat_n, step_lat, step_lat_n;
   logic [RATE_W-1:0] rate_lat, rate_lat_n;
   logic              loop_lat, loop_lat_n, up, up_n;

   logic [5:0]        sum6, dif6;
   logic [4:0]        stepped;
   logic              expire;

   assign busy   = (state != IDLE);
   assign expire = cen && (cnt == rate_lat);
   assign sum6   = {1'b0, period} + {1'b0, step_lat};
   assign dif6   = {1'b0, period} - {1'b0, step_lat};

   // Next period toward the end point, clamped at the end (this also absorbs wrap past 0 or 31).
   always_comb begin
      stepped = period;
      if (up) begin
         if (sum6 > {1'b0, e_lat}) stepped = e_lat;
         else                      stepped = sum6[4:0];
      end else begin
         if (dif6[5] || (dif6[4:0] < e_lat)) stepped = e_lat;
         else                                stepped = dif6[4:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         period   <= 5'd0;
         wr       <= 1'b0;
         done     <= 1'b0;
         cnt      <= '0;
         s_lat    <= 5'd0;
         e_lat    <= 5'd0;
         step_lat <= 5'd0;
         rate_lat <= '0;
         loop_lat <= 1'b0;
         up       <= 1'b1;
      end else begin
         state    <= state_n;
         period   <= period_n;
         wr       <= wr_n;
         done     <= done_n;
         cnt      <= cnt_n;
         s_lat    <= s_lat_n;
         e_lat    <= e_lat_n;
         step_lat <= step_lat_n;
         rate_lat <= rate_lat_n;
         loop_lat <= loop_lat_n;
         up       <= up_n;
      end
   end

   always_comb begin
      state_n    = state;
      period_n   = period;
      wr_n       = 1'b0;
      done_n     = 1'b0;
      cnt_n      = cnt;
      s_lat_n    = s_lat;
      e_lat_n    = e_lat;
      step_lat_n = step_lat;
      rate_lat_n = rate_lat;
      loop_lat_n = loop_lat;
      up_n       = up;

      if (stop && state != IDLE) begin
         state_n = IDLE;
         done_n  = 1'b1;
         cnt_n   = '0;
      end else if (start && !stop) begin
         // Restart from any state; an interrupted sweep gives no done pulse.
         s_lat_n    = cfg_start;
         e_lat_n    = cfg_end;
         step_lat_n = cfg_step;
         rate_lat_n = cfg_rate;
         loop_lat_n = cfg_loop;
         up_n       = (cfg_end >= cfg_start);
         period_n   = cfg_start;
         wr_n       = 1'b1;
         cnt_n      = '0;
         state_n    = (cfg_start == cfg_end) ? LAST : RUN;
      end else if (state != IDLE && cen) begin
         if (!expire) begin
            cnt_n = cnt + RATE_W'(1);
         end else begin
            cnt_n = '0;
            case (state)
               RUN: begin
                  // A zero step never changes the period, so the sweep idles here until stopped.
                  if (stepped != period) begin
                     period_n = stepped;
                     wr_n     = 1'b1;
                  end
                  if (stepped == e_lat) state_n = LAST;
               end
               LAST: begin
                  if (loop_lat) begin
`ifdef JT49_SWEEP_PINGPONG_EN
                     s_lat_n = e_lat;
                     e_lat_n = s_lat;
                     up_n    = !up;
                     state_n = (s_lat == e_lat) ? LAST : RUN;
`else
                     period_n = s_lat;
                     wr_n     = 1'b1;
                     state_n  = (s_lat == e_lat) ? LAST : RUN;
`endif
                  end else begin
                     state_n = IDLE;
                     done_n  = 1'b1;
                  end
               end
               default: state_n = IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jt49_noise_sweep.sv
// tb/tb_jt49_noise_sweep.sv - directed and random checks of jt49_noise_sweep against a sequence-list model
// Honours JT49_SWEEP_PINGPONG_EN in the model when the macro is defined.
module tb_jt49_noise_sweep;

   logic       clk = 1'b0;
   logic       rst, cen, start, stop, cfg_loop;
   logic [4:0] cfg_start, cfg_end, cfg_step;
   logic [7:0] cfg_rate;
   logic [4:0] period;
   logic       wr, busy, done;

   int total = 0;
   int bad   = 0;

   jt49_noise_sweep #(.RATE_W(8)) dut (
      .clk(clk), .rst(rst), .cen(cen), .start(start), .stop(stop),
      .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_step(cfg_step),
      .cfg_rate(cfg_rate), .cfg_loop(cfg_loop),
      .period(period), .wr(wr), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Model: the whole list of periods a sweep visits, plus a cen-cycle count per value.
   int   m_seq[$];
   int   m_idx, m_cnt, m_rate, m_s, m_e, m_step;
   logic m_loop;
   logic [4:0] m_period = 5'd0;
   logic m_wr = 1'b0, m_busy = 1'b0, m_done = 1'b0;

   function automatic void build_seq();
      int v;
      m_seq.delete();
      v = m_s;
      m_seq.push_back(v);
      if (m_step != 0) begin
         while (v != m_e) begin
            if (m_e >= m_s) v = (v + m_step > m_e) ? m_e : v + m_step;
            else            v = (v - m_step < m_e) ? m_e : v - m_step;
            m_seq.push_back(v);
         end
      end
   endfunction

   function automatic void model_step();
      int t;
      m_wr   = 1'b0;
      m_done = 1'b0;
      if (rst) begin
         m_period = 5'd0;
         m_busy   = 1'b0;
         m_cnt    = 0;
      end else if (stop && m_busy) begin
         m_busy = 1'b0;
         m_done = 1'b1;
      end else if (start && !stop) begin
         m_s = cfg_start; m_e = cfg_end; m_step = cfg_step;
         m_rate = cfg_rate; m_loop = cfg_loop;
         build_seq();
         m_idx = 0; m_cnt = 0;
         m_period = 5'(m_seq[0]);
         m_wr = 1'b1; m_busy = 1'b1;
      end else if (m_busy && cen) begin
         m_cnt++;
         if (m_cnt > m_rate) begin
            m_cnt = 0;
            if (m_idx < m_seq.size() - 1) begin
               m_idx++;
               m_period = 5'(m_seq[m_idx]);
               m_wr = 1'b1;
            end else if (m_step == 0 && m_s != m_e) begin
               m_idx = 0;
            end else if (m_loop) begin
`ifdef JT49_SWEEP_PINGPONG_EN
               t = m_s; m_s = m_e; m_e = t;
               build_seq();
               m_idx = 0;
`else
               m_idx = 0;
               m_period = 5'(m_seq[0]);
               m_wr = 1'b1;
`endif
            end else begin
               m_busy = 1'b0;
               m_done = 1'b1;
            end
         end
      end
   endfunction

   task automatic check();
      total++;
      assert (period === m_period) else begin bad++; $error("FAIL period got=%0d exp=%0d", period, m_period); end
      total++;
      assert (wr === m_wr) else begin bad++; $error("FAIL wr got=%0b exp=%0b", wr, m_wr); end
      total++;
      assert (busy === m_busy) else begin bad++; $error("FAIL busy got=%0b exp=%0b", busy, m_busy); end
      total++;
      assert (done === m_done) else begin bad++; $error("FAIL done got=%0b exp=%0b", done, m_done); end
      total++;
      assert ((wr & done) === 1'b0) else begin bad++; $error("FAIL wr_done_overlap got=%0b exp=0", wr & done); end
   endtask

   task automatic tick(input logic r, input logic st, input logic sp, input logic c);
      @(negedge clk);
      rst = r; start = st; stop = sp; cen = c;
      model_step();
      @(posedge clk);
      #1;
      check();
   endtask

   task automatic set_cfg(input int s, input int e, input int st, input int rt, input logic lp);
      cfg_start = 5'(s); cfg_end = 5'(e); cfg_step = 5'(st); cfg_rate = 8'(rt); cfg_loop = lp;
   endtask

   int got[$];

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; cen = 1'b0;
      set_cfg(0, 0, 0, 0, 1'b0);
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 1);
      for (int i = 0; i < 20; i++) tick(0, 0, 0, 1);

      // Simple rising sweep; also checked against the literal value list
      set_cfg(1, 9, 4, 2, 1'b0);
      tick(0, 1, 0, 1);
      got.delete();
      if (wr) got.push_back(period);
      for (int i = 0; i < 14; i++) begin
         tick(0, 0, 0, 1);
         if (wr) got.push_back(period);
      end
      total++;
      assert (got.size() === 3) else begin bad++; $error("FAIL up_seq_len got=%0d exp=3", got.size()); end
      if (got.size() == 3) begin
         total++;
         assert (got[0] == 1 && got[1] == 5 && got[2] == 9)
            else begin bad++; $error("FAIL up_seq got=%0d,%0d,%0d exp=1,5,9", got[0], got[1], got[2]); end
      end

      // Falling sweep with clamp, cen every other cycle
      set_cfg(20, 3, 8, 0, 1'b0);
      tick(0, 1, 0, 1);
      for (int i = 0; i < 16; i++) tick(0, 0, 0, i[0]);

      // Looping sweep, stop mid-sweep, simultaneous start/stop
      set_cfg(2, 6, 2, 1, 1'b1);
      tick(0, 1, 0, 1);
      for (int i = 0; i < 15; i++) tick(0, 0, 0, 1);
      tick(0, 0, 1, 1);
      for (int i = 0; i < 4; i++) tick(0, 0, 0, 1);
      tick(0, 1, 1, 1);
      for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);
      tick(0, 1, 0, 1);
      for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);
      tick(0, 1, 1, 1);
      for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);

      // Full-range step, then zero step held until stop
      set_cfg(0, 31, 31, 0, 1'b0);
      tick(0, 1, 0, 1);
      for (int i = 0; i < 5; i++) tick(0, 0, 0, 1);
      set_cfg(0, 31, 0, 0, 1'b0);
      tick(0, 1, 0, 1);
      for (int i = 0; i < 10; i++) tick(0, 0, 0, 1);
      tick(0, 0, 1, 1);
      for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);

      // Looping 4..8 (reload or ping-pong depending on build), then reset mid-sweep
      set_cfg(4, 8, 2, 0, 1'b1);
      tick(0, 1, 0, 1);
      for (int i = 0; i < 20; i++) tick(0, 0, 0, 1);
      tick(1, 0, 0, 1);
      for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         logic r, st, sp, c;
         r  = ($urandom_range(0, 599) == 0);
         st = ($urandom_range(0, 39) == 0);
         sp = ($urandom_range(0, 69) == 0);
         c  = ($urandom_range(0, 3) != 0);
         if (st) set_cfg($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                         $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         tick(r, st, sp, c);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
